// File: rtl/lcd_timing_gen.sv
// Parallel-RGB LCD/VGA timing generator with test patterns.
// Registered outputs trail the raster counters by exactly one clock.
module lcd_timing_gen #(
    parameter int H_ACTIVE    = 800,
    parameter int H_FP        = 40,
    parameter int H_SYNC      = 48,
    parameter int H_BP        = 88,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 13,
    parameter int V_SYNC      = 3,
    parameter int V_BP        = 32,
    parameter int HS_POL      = 0,
    parameter int VS_POL      = 0,
    parameter int CBITS       = 6,
    parameter int TICK_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         mode,
    input  logic [3*CBITS-1:0] solid_rgb,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [CBITS-1:0]   red,
    output logic [CBITS-1:0]   green,
    output logic [CBITS-1:0]   blue,
    output logic [10:0]        x,
    output logic [9:0]         y,
    output logic               frame_start,
    output logic               sec_tick,
    output logic [7:0]         frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int TW      = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
    localparam int PW      = 3 * CBITS;

    localparam logic [10:0] HT_M1 = 11'(H_TOTAL - 1);
    localparam logic [10:0] HA    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_B  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_E  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] BW_M1 = 11'(H_ACTIVE / 8 - 1);
    localparam logic [9:0]  VT_M1 = 10'(V_TOTAL - 1);
    localparam logic [9:0]  VA    = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_B  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_E  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [TW-1:0] TF_M1 = TW'(TICK_FRAMES - 1);
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    // raster and bar counters
    logic [10:0]   hc_q, hc_d;
    logic [9:0]    vc_q, vc_d;
    logic [10:0]   bw_q, bw_d;
    logic [2:0]    bi_q, bi_d;
    // per-frame shadow of the pattern controls
    logic [1:0]    mode_q, mode_d;
    logic [PW-1:0] solid_q, solid_d;
    logic [TW-1:0] tick_q, tick_d;
    // registered outputs
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          de_q, de_d;
    logic [PW-1:0] rgb_q, rgb_d;
    logic [10:0]   x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic          fs_q, fs_d;
    logic          st_q, st_d;
    logic [7:0]    fc_q, fc_d;

    logic          origin;
    logic          active;
    logic [PW-1:0] pix;

    assign origin = (hc_q == 11'd0) && (vc_q == 10'd0);
    assign active = (hc_q < HA) && (vc_q < VA);

    // raster advance; the bar index restarts at the start of every line
    always_comb begin
        hc_d = hc_q + 11'd1;
        vc_d = vc_q;
        bw_d = bw_q + 11'd1;
        bi_d = bi_q;
        if (hc_q == HT_M1) begin
            hc_d = 11'd0;
            bw_d = 11'd0;
            bi_d = 3'd0;
            vc_d = (vc_q == VT_M1) ? 10'd0 : vc_q + 10'd1;
        end else if (bw_q == BW_M1) begin
            bw_d = 11'd0;
            bi_d = bi_q + 3'd1;
        end
    end

    // controls are sampled at pixel (0,0) and bypassed on that same cycle
    always_comb begin
        mode_d  = origin ? mode : mode_q;
        solid_d = origin ? solid_rgb : solid_q;
    end

    // pattern generator; bar colours derive directly from the index bits
    always_comb begin
        pix = '0;
        unique case (mode_d)
            2'd0: pix = solid_d;
            2'd1: pix = {{CBITS{~bi_q[1]}}, {CBITS{~bi_q[2]}},
                         {CBITS{~bi_q[0]}}};
            2'd2: pix = (hc_q[4] ^ vc_q[4]) ? solid_d : '0;
            2'd3: pix = {3{vc_q[CBITS+2:3]}};
            default: pix = '0;
        endcase
    end

    // next output values, including frame and second tick bookkeeping
    always_comb begin
        hs_d   = ((hc_q >= HS_B) && (hc_q < HS_E)) ? HS_ON : ~HS_ON;
        vs_d   = ((vc_q >= VS_B) && (vc_q < VS_E)) ? VS_ON : ~VS_ON;
        de_d   = active;
        rgb_d  = active ? pix : '0;
        x_d    = hc_q;
        y_d    = vc_q;
        fs_d   = origin;
        st_d   = 1'b0;
        fc_d   = fc_q;
        tick_d = tick_q;
        if (origin) begin
            fc_d = fc_q + 8'd1;
            if (tick_q == TF_M1) begin
                tick_d = '0;
                st_d   = 1'b1;
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end
    end

    // state register; reset overrides all counting
    always_ff @(posedge clk) begin
        if (reset) begin
            hc_q    <= '0;
            vc_q    <= '0;
            bw_q    <= '0;
            bi_q    <= '0;
            mode_q  <= '0;
            solid_q <= '0;
            tick_q  <= '0;
            hs_q    <= ~HS_ON;
            vs_q    <= ~VS_ON;
            de_q    <= 1'b0;
            rgb_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            fs_q    <= 1'b0;
            st_q    <= 1'b0;
            fc_q    <= '0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            bw_q    <= bw_d;
            bi_q    <= bi_d;
            mode_q  <= mode_d;
            solid_q <= solid_d;
            tick_q  <= tick_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            rgb_q   <= rgb_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fs_q    <= fs_d;
            st_q    <= st_d;
            fc_q    <= fc_d;
        end
    end

    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign de          = de_q;
    assign red         = rgb_q[PW-1 -: CBITS];
    assign green       = rgb_q[2*CBITS-1 -: CBITS];
    assign blue        = rgb_q[CBITS-1:0];
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = fs_q;
    assign sec_tick    = st_q;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: a mid-size raster and a tiny raster,
// both compared every cycle against a frame-position reference model.
module tb_lcd_timing_gen;

    localparam int P_HA[2] = '{64, 8};
    localparam int P_HF[2] = '{4, 1};
    localparam int P_HS[2] = '{6, 1};
    localparam int P_HB[2] = '{6, 1};
    localparam int P_VA[2] = '{40, 4};
    localparam int P_VF[2] = '{2, 1};
    localparam int P_VS[2] = '{3, 1};
    localparam int P_VB[2] = '{3, 1};
    localparam int P_HP[2] = '{0, 1};
    localparam int P_VP[2] = '{0, 1};
    localparam int P_TF[2] = '{2, 3};
    localparam int BARS[8] = '{7, 6, 3, 2, 5, 4, 1, 0};
    localparam int HT0     = 80;

    typedef struct {
        int x, y, de, hs, vs, r, g, b, fs, st, fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst0, rst1;
    logic [1:0]  md0, md1;
    logic [17:0] sol0, sol1;

    logic        hs0, vs0, de0, fs0, st0;
    logic [5:0]  r0, g0, b0;
    logic [10:0] x0;
    logic [9:0]  y0;
    logic [7:0]  fc0;
    logic        hs1, vs1, de1, fs1, st1;
    logic [5:0]  r1, g1, b1;
    logic [10:0] x1;
    logic [9:0]  y1;
    logic [7:0]  fc1;

    int checks = 0;
    int errors = 0;
    int nxt[2];
    int smode[2];
    int ssol[2];
    int nfs[2];

    always #5 clk = ~clk;

    lcd_timing_gen #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(3), .V_BP(3),
        .HS_POL(0), .VS_POL(0), .CBITS(6), .TICK_FRAMES(2)
    ) u_mid (
        .clk(clk), .reset(rst0), .mode(md0), .solid_rgb(sol0),
        .hsync(hs0), .vsync(vs0), .de(de0),
        .red(r0), .green(g0), .blue(b0), .x(x0), .y(y0),
        .frame_start(fs0), .sec_tick(st0), .frame_count(fc0)
    );

    lcd_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .CBITS(6), .TICK_FRAMES(3)
    ) u_tiny (
        .clk(clk), .reset(rst1), .mode(md1), .solid_rgb(sol1),
        .hsync(hs1), .vsync(vs1), .de(de1),
        .red(r1), .green(g1), .blue(b1), .x(x1), .y(y1),
        .frame_start(fs1), .sec_tick(st1), .frame_count(fc1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d (t=%0t)",
                   tag, obs, exp, $time);
        end
    endtask

    // Reference: each sampled edge either resets or shows the next
    // pixel of the frame, addressed as a linear position.
    task automatic model(input int k, input bit rst, input int md,
                         input int sol, output exp_t e);
        int ht, vt, pos, hsb, vsb, code, c;
        ht = P_HA[k] + P_HF[k] + P_HS[k] + P_HB[k];
        vt = P_VA[k] + P_VF[k] + P_VS[k] + P_VB[k];
        e = '{default: 0};
        if (rst) begin
            nxt[k] = 0;
            nfs[k] = 0;
            smode[k] = 0;
            ssol[k] = 0;
            e.hs = (P_HP[k] != 0) ? 0 : 1;
            e.vs = (P_VP[k] != 0) ? 0 : 1;
        end else begin
            pos = nxt[k];
            e.x = pos % ht;
            e.y = pos / ht;
            if (pos == 0) begin
                smode[k] = md;
                ssol[k] = sol;
                nfs[k]++;
                e.fs = 1;
                e.st = ((nfs[k] % P_TF[k]) == 0) ? 1 : 0;
            end
            e.fc = nfs[k] % 256;
            hsb = P_HA[k] + P_HF[k];
            vsb = P_VA[k] + P_VF[k];
            if (e.x >= hsb && e.x < hsb + P_HS[k])
                e.hs = (P_HP[k] != 0) ? 1 : 0;
            else
                e.hs = (P_HP[k] != 0) ? 0 : 1;
            if (e.y >= vsb && e.y < vsb + P_VS[k])
                e.vs = (P_VP[k] != 0) ? 1 : 0;
            else
                e.vs = (P_VP[k] != 0) ? 0 : 1;
            e.de = (e.x < P_HA[k] && e.y < P_VA[k]) ? 1 : 0;
            if (e.de == 1) begin
                case (smode[k])
                    0: begin
                        e.r = (ssol[k] >> 12) & 63;
                        e.g = (ssol[k] >> 6) & 63;
                        e.b = ssol[k] & 63;
                    end
                    1: begin
                        code = BARS[e.x / (P_HA[k] / 8)];
                        e.r = code[2] ? 63 : 0;
                        e.g = code[1] ? 63 : 0;
                        e.b = code[0] ? 63 : 0;
                    end
                    2: begin
                        if (((e.x / 16) % 2) != ((e.y / 16) % 2)) begin
                            e.r = (ssol[k] >> 12) & 63;
                            e.g = (ssol[k] >> 6) & 63;
                            e.b = ssol[k] & 63;
                        end
                    end
                    default: begin
                        c = (e.y / 8) % 64;
                        e.r = c;
                        e.g = c;
                        e.b = c;
                    end
                endcase
            end
            nxt[k] = (pos + 1) % (ht * vt);
        end
    endtask

    task automatic cmp(input int k, input exp_t o, input exp_t e);
        chk($sformatf("x%0d", k), o.x, e.x);
        chk($sformatf("y%0d", k), o.y, e.y);
        chk($sformatf("de%0d", k), o.de, e.de);
        chk($sformatf("hsync%0d", k), o.hs, e.hs);
        chk($sformatf("vsync%0d", k), o.vs, e.vs);
        chk($sformatf("red%0d", k), o.r, e.r);
        chk($sformatf("green%0d", k), o.g, e.g);
        chk($sformatf("blue%0d", k), o.b, e.b);
        chk($sformatf("frame_start%0d", k), o.fs, e.fs);
        chk($sformatf("sec_tick%0d", k), o.st, e.st);
        chk($sformatf("frame_count%0d", k), o.fc, e.fc);
    endtask

    task automatic step();
        exp_t e0, e1, o0, o1;
        @(posedge clk);
        model(0, rst0, int'(md0), int'(sol0), e0);
        model(1, rst1, int'(md1), int'(sol1), e1);
        #1;
        o0 = '{x: int'(x0), y: int'(y0), de: int'(de0), hs: int'(hs0),
               vs: int'(vs0), r: int'(r0), g: int'(g0), b: int'(b0),
               fs: int'(fs0), st: int'(st0), fc: int'(fc0)};
        o1 = '{x: int'(x1), y: int'(y1), de: int'(de1), hs: int'(hs1),
               vs: int'(vs1), r: int'(r1), g: int'(g1), b: int'(b1),
               fs: int'(fs1), st: int'(st1), fc: int'(fc1)};
        cmp(0, o0, e0);
        cmp(1, o1, e1);
    endtask

    // Step until the mid raster's next pixel is at position p.
    task automatic run_to(input int p);
        int n;
        n = 0;
        while (nxt[0] != p && n < 5000) begin
            step();
            n++;
        end
        chk("run_to_bound", (nxt[0] == p) ? 1 : 0, 1);
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        md0  = 2'd0;
        md1  = 2'($urandom_range(0, 3));
        sol0 = 18'h3f000;
        sol1 = 18'($urandom);
        nxt  = '{0, 0};
        smode = '{0, 0};
        ssol = '{0, 0};
        nfs  = '{0, 0};

        repeat (5) step();
        chk("reset_hsync", int'(hs0), 1);
        chk("reset_vsync", int'(vs0), 1);
        chk("reset_fc", int'(fc0), 0);

        rst0 = 1'b0;
        rst1 = 1'b0;
        step();
        chk("first_fs", int'(fs0), 1);
        chk("first_xy", int'({x0, y0}), 0);

        // Solid red frame; bars requested mid-frame must wait.
        run_to(20 * HT0);
        md0 = 2'd1;
        run_to(0);
        step();
        chk("bars_white", int'({r0, g0, b0}), 18'h3ffff);
        // Grey ramp requested mid-frame of the bars frame.
        run_to(20 * HT0);
        md0 = 2'd3;
        run_to(8 * HT0 + 1);
        chk("grey_line8", int'({r0, g0, b0}), 18'h01041);

        // Checker frame, then a one-cycle reset at hc=5, vc=2.
        md0  = 2'd2;
        sol0 = 18'($urandom);
        run_to(0);
        run_to(2 * HT0 + 5);
        rst0 = 1'b1;
        step();
        rst0 = 1'b0;
        step();
        chk("restart_fs", int'(fs0), 1);

        // Random control changes and occasional resets.
        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                md0  = 2'($urandom_range(0, 3));
                sol0 = 18'($urandom);
            end
            if ($urandom_range(0, 149) == 0) begin
                md1  = 2'($urandom_range(0, 3));
                sol1 = 18'($urandom);
            end
            rst0 = ($urandom_range(0, 2999) == 0);
            rst1 = (i > 11500) && ($urandom_range(0, 199) == 0);
            step();
        end
        rst0 = 1'b0;
        rst1 = 1'b0;
        repeat (100) step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
